// File: rtl/mc_ctrl_if.sv
// Bus between the multi-cycle main controller and the datapath: instruction
// fields and ALU flags in, datapath control strobes and debug state out.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             neg;
    logic             pc_wr;
    logic             ir_wr;
    logic [1:0]       npc_sel;
    logic             rf_wr;
    logic [1:0]       reg_dst;
    logic [1:0]       wb_sel;
    logic             alu_src;
    logic [1:0]       ext_op;
    logic [1:0]       alu_op;
    logic             mem_wr;
    logic             retire;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] icount;

    modport master (
        input  op, funct, zero, neg,
        output pc_wr, ir_wr, npc_sel, rf_wr, reg_dst, wb_sel, alu_src,
               ext_op, alu_op, mem_wr, retire, illegal, state, icount
    );

    modport slave (
        output op, funct, zero, neg,
        input  pc_wr, ir_wr, npc_sel, rf_wr, reg_dst, wb_sel, alu_src,
               ext_op, alu_op, mem_wr, retire, illegal, state, icount
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/write-back, plus a retired-instruction counter.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_FETCH = 4'd1,
        S_DCD   = 4'd2,
        S_EXE   = 4'd3,
        S_WB    = 4'd4,
        S_MA    = 4'd5,
        S_MR    = 4'd6,
        S_MWB   = 4'd7,
        S_MW    = 4'd8,
        S_BR    = 4'd9,
        S_JMP   = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        C_ILL  = 4'd0,
        C_ADDU = 4'd1,
        C_SUBU = 4'd2,
        C_JR   = 4'd3,
        C_ORI  = 4'd4,
        C_LUI  = 4'd5,
        C_LW   = 4'd6,
        C_SW   = 4'd7,
        C_BEQ  = 4'd8,
        C_BLEZ = 4'd9,
        C_J    = 4'd10,
        C_JAL  = 4'd11
    } cls_t;

    function automatic cls_t decode_cls(input logic [5:0] op, input logic [5:0] funct);
        cls_t c;
        c = C_ILL;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: c = C_ADDU;
                    6'b100011: c = C_SUBU;
                    6'b001000: c = C_JR;
                    default:   c = C_ILL;
                endcase
            end
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b000110: c = C_BLEZ;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    state_t           state_r;
    state_t           next_s;
    cls_t             cls_r;
    cls_t             dcd_cls_s;
    logic [CNT_W-1:0] icount_r;

    logic       pc_wr_s;
    logic       ir_wr_s;
    logic [1:0] npc_sel_s;
    logic       rf_wr_s;
    logic [1:0] reg_dst_s;
    logic [1:0] wb_sel_s;
    logic       alu_src_s;
    logic [1:0] ext_op_s;
    logic [1:0] alu_op_s;
    logic       mem_wr_s;
    logic       retire_s;
    logic       illegal_s;

    // Live decode of the instruction fields; only consumed in DCD.
    always_comb begin
        dcd_cls_s = decode_cls(bus.op, bus.funct);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_INIT;
        end else begin
            state_r <= next_s;
        end
    end

    // Class is captured in DCD and held so later op/funct changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_r <= C_ILL;
        end else if (state_r == S_DCD) begin
            cls_r <= dcd_cls_s;
        end else begin
            cls_r <= cls_r;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icount_r <= '0;
        end else if (retire_s) begin
            icount_r <= icount_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            icount_r <= icount_r;
        end
    end

    // Next-state and Moore control outputs.
    always_comb begin
        next_s    = S_INIT;
        pc_wr_s   = 1'b0;
        ir_wr_s   = 1'b0;
        npc_sel_s = 2'b00;
        rf_wr_s   = 1'b0;
        reg_dst_s = 2'b00;
        wb_sel_s  = 2'b00;
        alu_src_s = 1'b0;
        ext_op_s  = 2'b00;
        alu_op_s  = 2'b00;
        mem_wr_s  = 1'b0;
        retire_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_r)
            S_INIT: next_s = S_FETCH;
            S_FETCH: begin
                ir_wr_s   = 1'b1;
                pc_wr_s   = 1'b1;
                npc_sel_s = 2'b00;
                next_s    = S_DCD;
            end
            S_DCD: begin
                case (dcd_cls_s)
                    C_ADDU, C_SUBU, C_ORI, C_LUI: next_s = S_EXE;
                    C_LW, C_SW:                   next_s = S_MA;
                    C_BEQ, C_BLEZ:                next_s = S_BR;
                    C_J, C_JAL, C_JR:             next_s = S_JMP;
                    default: begin
                        illegal_s = 1'b1;
                        next_s    = S_FETCH;
                    end
                endcase
            end
            S_EXE, S_WB: begin
                // WB keeps the ALU set up so the result stays stable while written.
                case (cls_r)
                    C_ADDU: begin
                        alu_op_s  = 2'b00;
                        alu_src_s = 1'b0;
                    end
                    C_SUBU: begin
                        alu_op_s  = 2'b01;
                        alu_src_s = 1'b0;
                    end
                    C_ORI: begin
                        alu_op_s  = 2'b10;
                        alu_src_s = 1'b1;
                        ext_op_s  = 2'b00;
                    end
                    C_LUI: begin
                        alu_op_s  = 2'b10;
                        alu_src_s = 1'b1;
                        ext_op_s  = 2'b10;
                    end
                    default: alu_op_s = 2'b00;
                endcase
                if (state_r == S_WB) begin
                    rf_wr_s  = 1'b1;
                    wb_sel_s = 2'b00;
                    if ((cls_r == C_ADDU) || (cls_r == C_SUBU)) begin
                        reg_dst_s = 2'b01;
                    end else begin
                        reg_dst_s = 2'b00;
                    end
                    retire_s = 1'b1;
                    next_s   = S_FETCH;
                end else begin
                    next_s = S_WB;
                end
            end
            S_MA, S_MR, S_MW: begin
                alu_op_s  = 2'b00;
                alu_src_s = 1'b1;
                ext_op_s  = 2'b01;
                case (state_r)
                    S_MA: begin
                        if (cls_r == C_SW) begin
                            next_s = S_MW;
                        end else begin
                            next_s = S_MR;
                        end
                    end
                    S_MR: next_s = S_MWB;
                    default: begin
                        mem_wr_s = 1'b1;
                        retire_s = 1'b1;
                        next_s   = S_FETCH;
                    end
                endcase
            end
            S_MWB: begin
                rf_wr_s   = 1'b1;
                wb_sel_s  = 2'b01;
                reg_dst_s = 2'b00;
                retire_s  = 1'b1;
                next_s    = S_FETCH;
            end
            S_BR: begin
                alu_op_s  = 2'b01;
                alu_src_s = 1'b0;
                npc_sel_s = 2'b01;
                if (cls_r == C_BLEZ) begin
                    pc_wr_s = bus.zero | bus.neg;
                end else begin
                    pc_wr_s = bus.zero;
                end
                retire_s = 1'b1;
                next_s   = S_FETCH;
            end
            S_JMP: begin
                pc_wr_s = 1'b1;
                if (cls_r == C_JR) begin
                    npc_sel_s = 2'b11;
                end else begin
                    npc_sel_s = 2'b10;
                end
                if (cls_r == C_JAL) begin
                    rf_wr_s   = 1'b1;
                    reg_dst_s = 2'b10;
                    wb_sel_s  = 2'b10;
                end else begin
                    rf_wr_s   = 1'b0;
                end
                retire_s = 1'b1;
                next_s   = S_FETCH;
            end
            default: next_s = S_INIT;
        endcase
    end

    assign bus.pc_wr   = pc_wr_s;
    assign bus.ir_wr   = ir_wr_s;
    assign bus.npc_sel = npc_sel_s;
    assign bus.rf_wr   = rf_wr_s;
    assign bus.reg_dst = reg_dst_s;
    assign bus.wb_sel  = wb_sel_s;
    assign bus.alu_src = alu_src_s;
    assign bus.ext_op  = ext_op_s;
    assign bus.alu_op  = alu_op_s;
    assign bus.mem_wr  = mem_wr_s;
    assign bus.retire  = retire_s;
    assign bus.illegal = illegal_s;
    assign bus.state   = state_r;
    assign bus.icount  = icount_r;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS core. A Moore state machine sequences instruction fetch, decode, execute, memory and write-back for the supported subset. It drives the next-PC unit (`npc_sel`, `pc_wr`), the IR, the register file, the ALU/extender muxes and data memory, and keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU result == 0.
- `neg`  in  1  ALU result bit 31.
- `pc_wr`  out  1  PC register write enable.
- `ir_wr`  out  1  IR write enable.
- `npc_sel`  out  2  Next-PC select: 00 = seq, 01 = branch, 10 = j/jal, 11 = jr.
- `rf_wr`  out  1  Register-file write enable.
- `reg_dst`  out  2  Destination register: 00 = rt, 01 = rd, 10 = $31.
- `wb_sel`  out  2  Write-back source: 00 = ALU, 01 = mem, 10 = pc_4.
- `alu_src`  out  1  ALU B operand: 0 = rt, 1 = ext imm.
- `ext_op`  out  2  Extender mode: 00 = zero, 01 = sign, 10 = lui (imm<<16).
- `alu_op`  out  2  ALU function: 00 = add, 01 = sub, 10 = or.
- `mem_wr`  out  1  Data-memory write.
- `retire`  out  1  One-cycle pulse in the last state of each instruction.
- `illegal`  out  1  One-cycle pulse in DCD for an unsupported encoding.
- `state`  out  4  Current state, for debug.
- `icount`  out  CNT_W  Count of retired instructions.

## Operation
- Supported instructions (op/funct):
  - addu: 000000/100001
  - subu: 000000/100011
  - jr: 000000/001000
  - ori: 001101
  - lui: 001111
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - blez: 000110
  - j: 000010
  - jal: 000011
- In DCD, `op`/`funct` are decoded into an internal class register. The class is held until the next DCD, so later changes on `op`/`funct` are ignored.
- States (encoding):
  - INIT 0: all outputs 0 → FETCH.
  - FETCH 1: `ir_wr`=1, `pc_wr`=1, `npc_sel`=00 → DCD.
  - DCD 2: branches on the decoded class:
    - addu/subu/ori/lui → EXE
    - lw/sw → MA
    - beq/blez → BR
    - j/jal/jr → JMP
    - otherwise → FETCH with `illegal`=1 and `retire`=0
  - EXE 3: settings by instruction:
    - addu: `alu_op`=00, `alu_src`=0
    - subu: `alu_op`=01, `alu_src`=0
    - ori: `alu_op`=10, `alu_src`=1, `ext_op`=00
    - lui: `alu_op`=10 with rs=$0, `alu_src`=1, `ext_op`=10
    - Next state: WB.
  - WB 4: `rf_wr`=1, `wb_sel`=00; `reg_dst`=01 for R-type, 00 for I-type. Holds EXE's ALU controls. `retire`=1 → FETCH.
  - MA 5: `alu_op`=00, `alu_src`=1, `ext_op`=01 → MR for lw, MW for sw.
  - MR 6: holds MA's controls → MWB.
  - MWB 7: `rf_wr`=1, `wb_sel`=01, `reg_dst`=00, `retire`=1 → FETCH.
  - MW 8: `mem_wr`=1, holds MA's controls, `retire`=1 → FETCH.
  - BR 9: `alu_op`=01, `alu_src`=0, `npc_sel`=01, `retire`=1.
    - `pc_wr` = `zero` for beq, `zero`|`neg` for blez. This is combinational on the flags in this cycle.
    - Next state: FETCH.
  - JMP 10: `pc_wr`=1, `npc_sel`=10 (j/jal) or 11 (jr).
    - jal also sets `rf_wr`=1, `reg_dst`=10, `wb_sel`=10.
    - `retire`=1 → FETCH.
  - Codes 11–15: all outputs 0 → INIT.
- Any output not listed for a state is 0.
- `icount` increments by 1 on each clock edge where `retire`=1. It wraps from all-ones to 0. An illegal instruction does not count.

## Timing
- Outputs are combinational from `state`, the class register and `zero`/`neg`. They have no internal latency beyond the state register.
- Cycles per instruction, counted FETCH to FETCH:
  - addu/subu/ori/lui: 4
  - lw: 5
  - sw: 4
  - beq/blez: 3
  - j/jal/jr: 3
  - illegal: 2
- On `rst` assertion, at any time:
  - `state` goes to INIT and `icount` to 0 immediately, without waiting for a clock edge.
  - All outputs go to 0 immediately, including mid-instruction. A partially executed instruction is abandoned; a write that was in progress is cut.
- First FETCH occurs on the first rising edge after `rst` deasserts.
- A not-taken branch leaves PC at the FETCH-incremented value; `pc_wr`=0 in BR.

## Test plan
- Reset: assert `rst` mid-MW (`mem_wr`=1) → `mem_wr`, `state`, `icount` all go to 0 immediately. After release: INIT → FETCH (`ir_wr`=`pc_wr`=1).
- addu ($3=$1+$2), then lw → state traces 1,2,3,4,1,2,5,6,7,1.
  - WB: `rf_wr`=1, `reg_dst`=01.
  - MWB: `wb_sel`=01.
  - `icount`=2.
- beq with `zero`=1 → BR: `pc_wr`=1, `npc_sel`=01.
- beq with `zero`=0, `neg`=1 → `pc_wr`=0.
- blez with `neg`=1 → `pc_wr`=1.
- jal → JMP: `pc_wr`=1, `npc_sel`=10, `rf_wr`=1, `reg_dst`=10, `wb_sel`=10.
- jr (funct 001000) → `npc_sel`=11, `rf_wr`=0.
- Illegal op 111111 → `illegal` pulses for one cycle in DCD, next state FETCH, `icount` unchanged.
- Counter wrap: with `CNT_W`=4, retire 16 instructions → `icount` returns to 0.
